// File: rtl/ulaw_pkg.sv
// ulaw_pkg: constants and state encoding shared by the u-law compressor and
// decompressor.
//   ULAW_BIAS  bias added to the magnitude before the segment search
//   ULAW_CLIP  largest magnitude accepted before biasing (8158 + 33 = 13'h1FFF)
//   LIN_W      linear sample width (two's complement)
//   ENC_W      compressed code width {sign, seg[2:0], mant[3:0]}
package ulaw_pkg;
  localparam int LIN_W     = 14;
  localparam int ENC_W     = 8;
  localparam int ULAW_BIAS = 33;
  localparam int ULAW_CLIP = 8158;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SEARCH = 2'd2
  } ulaw_state_e;
endpackage

// File: rtl/ulaw_mag_bias.sv
// ulaw_mag_bias: combinational absolute value, clip and bias for one sample.
//   lin   in   LIN_W  signed linear sample
//   m     out  13     min(|lin|, ULAW_CLIP) + ULAW_BIAS
//   clip  out  1      magnitude was saturated to ULAW_CLIP
module ulaw_mag_bias
  import ulaw_pkg::*;
(
  input  logic [LIN_W-1:0] lin,
  output logic [12:0]      m,
  output logic             clip
);
  logic [LIN_W-1:0] mag;
  logic [12:0]      mag_c;

  // 14-bit negate: -8192 wraps to 14'h2000, which reads as +8192 unsigned.
  assign mag   = lin[LIN_W-1] ? (~lin + 1'b1) : lin;
  assign clip  = (mag > LIN_W'(ULAW_CLIP));
  assign mag_c = clip ? 13'(ULAW_CLIP) : mag[12:0];
  assign m     = mag_c + 13'(ULAW_BIAS);
endmodule

// File: rtl/ulaw_comp.sv
// ulaw_comp: iterative u-law compressor, 14-bit linear in, 8-bit code out.
// Code is {sign, seg[2:0], mant[3:0]}. Start/finish pulse handshake:
//   clk      in   system clock, rising edge
//   reset    in   async active-high reset (aborts a conversion, no finish)
//   start    in   one-cycle request, samples lin_in (ignored while busy)
//   lin_in   in   signed linear sample
//   enc_out  out  compressed code, held until the next finish
//   busy     out  conversion in flight
//   finish   out  one-cycle pulse, enc_out valid from this cycle
//   clipped  out  (ULAW_COMP_CLIP_FLAG_EN only) last sample saturated to CLIP
// Latency from the start edge: 2 + (7 - seg) cycles.
module ulaw_comp
  import ulaw_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LIN_W-1:0] lin_in,
  output logic [ENC_W-1:0] enc_out,
  output logic             busy,
  output logic             finish
`ifdef ULAW_COMP_CLIP_FLAG_EN
  ,
  output logic             clipped
`endif
);
  ulaw_state_e      state_q, state_d;
  logic             s_q;
  logic [LIN_W-1:0] lin_q;
  logic [12:0]      m_q;
  logic [2:0]       seg_q;
  logic [12:0]      mb_m;
  logic             mb_clip;
  logic             done;

  ulaw_mag_bias u_mag_bias (
    .lin  (lin_q),
    .m    (mb_m),
    .clip (mb_clip)
  );

  // Normalised once the leading one reaches bit 12, or out of segments.
  assign done = m_q[12] || (seg_q == 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SEARCH;
      ST_SEARCH: if (done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q     <= 1'b0;
      lin_q   <= '0;
      m_q     <= '0;
      seg_q   <= '0;
      enc_out <= '0;
      busy    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          s_q   <= lin_in[LIN_W-1];
          lin_q <= lin_in;
          busy  <= 1'b1;
        end
        ST_LOAD: begin
          m_q   <= mb_m;
          seg_q <= 3'd7;
        end
        ST_SEARCH: begin
          if (done) begin
            enc_out <= {s_q, seg_q, m_q[11:8]};
            finish  <= 1'b1;
            busy    <= 1'b0;
          end else begin
            m_q   <= m_q << 1;
            seg_q <= seg_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ULAW_COMP_CLIP_FLAG_EN
  logic clip_q;

  // Flag is latched at LOAD and published with enc_out at finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_q  <= 1'b0;
      clipped <= 1'b0;
    end else begin
      if (state_q == ST_LOAD) clip_q <= mb_clip;
      if (state_q == ST_SEARCH && done) clipped <= clip_q;
    end
  end
`else
  logic clip_unused;
  assign clip_unused = mb_clip;
`endif
endmodule

// File: tb/tb_ulaw_comp.sv
module tb_ulaw_comp;
  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic signed [13:0] lin_in;
  logic [7:0]        enc_out;
  logic              busy;
  logic              finish;
`ifdef ULAW_COMP_CLIP_FLAG_EN
  logic              clipped;
`endif

  int total = 0;
  int bad   = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  ulaw_comp dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .lin_in  (lin_in),
    .enc_out (enc_out),
    .busy    (busy),
    .finish  (finish)
`ifdef ULAW_COMP_CLIP_FLAG_EN
    ,
    .clipped (clipped)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits up to 20 edges for finish; optionally re-pulses start (with a
  // different sample) after edge poke_at to prove it is ignored while busy.
  task automatic wait_fin(output int lat, output bit seen, input int poke_at);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat   = i;
      if (busy) busy_cnt++;
      if (finish) begin
        seen = 1'b1;
        break;
      end
      if (i == poke_at) begin
        start  = 1'b1;
        lin_in = 14'sh1FFF;
      end
    end
  endtask

  task automatic run_conv(input logic signed [13:0] x, input int poke_at,
                          output logic [7:0] code, output int lat, output bit seen);
    @(negedge clk);
    start  = 1'b1;
    lin_in = x;
    @(posedge clk); #1;
    start    = 1'b0;
    lin_in   = ~x;          // must not disturb the captured sample
    busy_cnt = busy ? 1 : 0;
    wait_fin(lat, seen, poke_at);
    code = enc_out;
  endtask

  task automatic conv_chk(input string tag, input logic signed [13:0] x,
                          input logic [7:0] exp_code, input int exp_lat);
    logic [7:0] code;
    int         lat;
    bit         seen;
    run_conv(x, 0, code, lat, seen);
    chk({tag, "_code"}, code, exp_code);
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic count_fin(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (finish) n++;
    end
  endtask

  initial begin
    logic [7:0] code;
    int         lat, nfin, seg, mant, dec, ax, err;
    bit         seen;

    reset  = 1'b1;
    start  = 1'b0;
    lin_in = '0;
    #1;
    chk("rst_enc", enc_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fin", finish, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // zero: seg 0, full search, busy for all 9 cycles
    run_conv(14'sd0, 0, code, lat, seen);
    chk("zero_code", code, 8'h00);
    chk("zero_lat", lat, 9);
    chk("zero_busy", busy_cnt, 9);
    chk("zero_busy_end", busy, 1'b0);

    conv_chk("p100", 14'sd100, 8'h20, 7);
    conv_chk("p1000", 14'sd1000, 8'h50, 4);
    conv_chk("m1", -14'sd1, 8'h81, 9);

    conv_chk("p8191", 14'sd8191, 8'h7F, 2);
`ifdef ULAW_COMP_CLIP_FLAG_EN
    chk("p8191_clip", clipped, 1'b1);
`endif
    conv_chk("m8192", -14'sd8192, 8'hFF, 2);
`ifdef ULAW_COMP_CLIP_FLAG_EN
    chk("m8192_clip", clipped, 1'b1);
`endif
    conv_chk("p8158", 14'sd8158, 8'h7F, 2);
`ifdef ULAW_COMP_CLIP_FLAG_EN
    chk("p8158_clip", clipped, 1'b0);
`endif

    // start while busy is dropped, not queued
    run_conv(14'sd0, 3, code, lat, seen);
    chk("rep_code", code, 8'h00);
    chk("rep_lat", lat, 9);
    count_fin(12, nfin);
    chk("rep_noextra", nfin, 0);

    // back-to-back: second start lands in the finish cycle
    run_conv(14'sd100, 0, code, lat, seen);
    chk("b2b_fin", finish, 1'b1);
    conv_chk("b2b", 14'sd1000, 8'h50, 4);

    // async reset during SEARCH aborts without a finish pulse
    @(negedge clk);
    start  = 1'b1;
    lin_in = 14'sd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("ab_enc", enc_out, 8'h00);
    chk("ab_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    count_fin(12, nfin);
    chk("ab_nofin", nfin, 0);
    conv_chk("ab_next", -14'sd1, 8'h81, 9);

    // round trip through a reference decoder, strided sweep
    for (int x = -8192; x < 8192; x += 7) begin
      run_conv(14'(x), 0, code, lat, seen);
      chk("rt_fin", seen, 1'b1);
      seg  = int'(code[6:4]);
      mant = int'(code[3:0]);
      dec  = ((33 + 2 * mant) << seg) - 33;
      ax   = (x < 0) ? -x : x;
      if (ax > 8158) ax = 8158;
      err  = (dec > ax) ? dec - ax : ax - dec;
      if (err > (1 << seg)) $display("FAIL rt_err x=%0d code=%0h dec=%0d", x, code, dec);
      chk("rt_err", err <= (1 << seg), 1'b1);
      if (x != 0) chk("rt_sign", code[7], x < 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
